// File: rtl/alu_multicycle_if.sv
// Request/response handshake bundle for alu_multicycle.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_multicycle_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       Operation;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALUResult;

   modport master (
      output in_valid, Operation, SrcA, SrcB, out_ready,
      input  in_ready, out_valid, ALUResult
   );

   modport slave (
      input  in_valid, Operation, SrcA, SrcB, out_ready,
      output in_ready, out_valid, ALUResult
   );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops, bit-serial shifts
// (one position per cycle), valid/ready on both request and result sides.
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_multicycle_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_BEQ = 4'b1000;
   localparam logic [3:0] OP_BGE = 4'b1001;
   localparam logic [3:0] OP_BNE = 4'b1010;
   localparam logic [3:0] OP_SLT = 4'b1100;
   localparam logic [3:0] OP_JAL = 4'b1111;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] result;
   logic [SHW-1:0]   cnt;
   logic             in_ready_q;
   logic             out_valid_q;

   logic [WIDTH-1:0] alu_comb;
   logic [WIDTH-1:0] shift_step;
   logic [SHW-1:0]   shamt;
   logic             is_shift;
   logic             accept;

   assign shamt    = bus.SrcB[SHW-1:0];
   assign is_shift = (bus.Operation == OP_SLL) || (bus.Operation == OP_SRL) ||
                     (bus.Operation == OP_SRA);
   assign accept   = bus.in_valid && in_ready_q;

   // Shift ops load SrcA here; the SHIFT state then walks it one bit per cycle.
   always_comb begin
      // NOTE: default first so every path assigns alu_comb and no latch is inferred.
      alu_comb = '0;
      case (bus.Operation)
         OP_AND: alu_comb = bus.SrcA & bus.SrcB;
         OP_OR:  alu_comb = bus.SrcA | bus.SrcB;
         OP_ADD: alu_comb = bus.SrcA + bus.SrcB;
         OP_XOR: alu_comb = bus.SrcA ^ bus.SrcB;
         OP_SUB: alu_comb = bus.SrcA - bus.SrcB;
         OP_SLL, OP_SRL, OP_SRA: alu_comb = bus.SrcA;
         OP_BEQ: alu_comb = WIDTH'(bus.SrcA == bus.SrcB);
         OP_BNE: alu_comb = WIDTH'(bus.SrcA != bus.SrcB);
         OP_BGE: alu_comb = WIDTH'($signed(bus.SrcA) >= $signed(bus.SrcB));
         OP_SLT: alu_comb = WIDTH'($signed(bus.SrcA) <  $signed(bus.SrcB));
         OP_JAL: alu_comb = WIDTH'(1);
         default: alu_comb = '0;
      endcase
   end

   always_comb begin
      shift_step = result;
      case (op_q)
         OP_SLL:  shift_step = {result[WIDTH-2:0], 1'b0};
         OP_SRL:  shift_step = {1'b0, result[WIDTH-1:1]};
         OP_SRA:  shift_step = {result[WIDTH-1], result[WIDTH-1:1]};
         default: shift_step = result;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state       <= IDLE;
         op_q        <= OP_AND;
         result      <= '0;
         cnt         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q       <= bus.Operation;
                  result     <= alu_comb;
                  in_ready_q <= 1'b0;
                  if (is_shift && (shamt != '0)) begin
                     cnt   <= shamt;
                     state <= SHIFT;
                  end else begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               result <= shift_step;
               cnt    <= cnt - 1'b1;
               // Last shift lands on the same edge the counter hits zero.
               if (cnt == SHW'(1)) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.ALUResult = result;
endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; shift amount is SrcB[$clog2(WIDTH)-1:0].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  request carries a valid operation.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 Operation  input  4  ALU op code from ALU controller.
REQ-007 SrcA  input  WIDTH  operand A.
REQ-008 SrcB  input  WIDTH  operand B / shift amount.
REQ-009 out_valid  output  1  ALUResult holds a completed result.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 ALUResult  output  WIDTH  registered result.

Function
REQ-012 Op codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1000 BEQ, 1001 BGE, 1010 BNE, 1100 SLT/BLT, 1111 JAL.
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-014 Accept = in_valid && in_ready; on accept, Operation, SrcA, SrcB SHALL be captured; later input changes SHALL NOT affect the operation in flight.
REQ-015 Non-shift op: IDLE -> DONE on accept; result registered on the same edge; out_valid high the next cycle (latency 1).
REQ-016 Shift op (0100/0101/0111) with shamt>0: IDLE -> SHIFT; one bit position shifted per cycle; down-counter loaded with shamt; SHIFT -> DONE on the edge where counter reaches 0; out_valid first high shamt+1 cycles after accept.
REQ-017 Shift op with shamt==0: IDLE -> DONE directly, result = SrcA, latency 1.
REQ-018 SRL SHALL fill with 0; SRA SHALL fill with captured SrcA[WIDTH-1]; SLL SHALL fill LSB with 0; SrcB bits above shamt field ignored.
REQ-019 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-020 SLT/BLT and BGE SHALL compare signed two's complement; BEQ/BNE compare all WIDTH bits.
REQ-021 Compare/branch ops (1000,1001,1010,1100) SHALL produce ALUResult = 1 when condition true, else 0.
REQ-022 JAL (1111) SHALL produce ALUResult = 1 unconditionally.
REQ-023 Undefined codes (1011,1101,1110) SHALL produce ALUResult = 0 with latency 1.
REQ-024 In DONE, ALUResult and out_valid SHALL hold stable until out_ready high; DONE -> IDLE on out_valid && out_ready.
REQ-025 in_ready SHALL be 0 in SHIFT and DONE; in_valid then ignored (no queuing); max throughput one op per 2 cycles.
REQ-026 out_ready while not in DONE SHALL have no effect.
REQ-027 ALUResult SHALL change only on accept, during SHIFT, or reset.

Reset
REQ-028 While rst_n==0 at a rising edge: state <= IDLE, ALUResult <= 0, shift counter <= 0; out_valid=0, in_ready=1 after that edge.
REQ-029 Reset during SHIFT or DONE SHALL discard the in-flight op with no result presented.
REQ-030 in_valid asserted during the reset cycle SHALL NOT be accepted.

Verification
REQ-031 ADD SrcA=0xFFFFFFFF, SrcB=2, out_ready=1 -> out_valid 1 cycle after accept, ALUResult=0x00000001, then in_ready=1.
REQ-032 SRA SrcA=0x80000000, SrcB=0x00000024 (shamt 4) -> out_valid 5 cycles after accept, ALUResult=0xF8000000; SRL same operands -> 0x08000000.
REQ-033 SLT SrcA=0xFFFFFFFF, SrcB=1 -> 1; BGE same operands -> 0; BNE SrcA=SrcB=5 -> 0; JAL any -> 1; code 1110 -> 0.
REQ-034 SUB SrcA=3, SrcB=5, out_ready=0 for 6 cycles -> out_valid and ALUResult=0xFFFFFFFE stable all 6 cycles, in_ready=0, new in_valid ignored; IDLE one cycle after out_ready=1.
REQ-035 SLL SrcA=1, SrcB=31, rst_n=0 at 10th SHIFT cycle -> next cycle out_valid=0, ALUResult=0, in_ready=1; next ADD 2+2 -> 4.
REQ-036 SLL SrcA=0x1234, SrcB=0x20 (shamt 0) -> latency 1, ALUResult=0x00001234.
